// File: rtl/mem_responder.sv
// Single-port word memory answering byte/half/word loads and stores; resp_valid pulses WAIT_CYCLES+1 cycles after acceptance.
// One request in flight (req_ready only in IDLE); define MEM_RESPONDER_ALIGN_CHECK_EN to fault misaligned accesses instead of aligning them.
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic        resp_valid,
   output logic [31:0] read_data,
   output logic        error
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept;
   logic        enter_resp;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] load_word;

   // Request fields decoded straight from the ports
   logic [1:0]    in_size;
   logic [1:0]    in_off;
   logic [AW-1:0] in_idx;
   logic          in_err;

   // Latched request
   logic          wr_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic [1:0]    off_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdat_q;
   logic          err_q;

   // Operation seen by the memory on the edge entering RESP
   logic          op_write;
   logic [1:0]    op_size;
   logic [1:0]    op_off;
   logic [AW-1:0] op_idx;
   logic [31:0]   op_wdat;
   logic          op_err;
   logic          mem_we;
   logic [3:0]    be;
   logic [31:0]   wlane;

   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   fmt;

   assign req_ready  = (state == S_IDLE) && !reset;
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state == S_RESP) && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The counter is loaded with WAIT_CYCLES and leaves WAIT on the edge where it reaches 0
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = S_RESP;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = 4'(WAIT_CYCLES);
               end
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Size 11 behaves as a word; misaligned halves/words drop the offending offset bits
   assign in_size = (req_size == 2'b11) ? 2'b10 : req_size;
   assign in_off  = (in_size == 2'b00) ? address[1:0] :
                    (in_size == 2'b01) ? {address[1], 1'b0} : 2'b00;
   assign in_idx  = address[AW+1:2];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
   assign in_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && address[0]) ||
                   ((req_size == 2'b10) && (address[1:0] != 2'b00));
`else
   assign in_err = 1'b0;
`endif

   generate
      if (AW < 30) begin : g_unused_addr
         logic unused_addr_bits;
         assign unused_addr_bits = ^address[31:AW+2];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (accept) begin
         wr_q   <= req_write;
         size_q <= in_size;
         uns_q  <= req_unsigned;
         off_q  <= in_off;
         idx_q  <= in_idx;
         wdat_q <= write_data;
         err_q  <= in_err;
      end
   end

   // With zero wait states RESP is entered on the acceptance edge itself, before the latches hold the request
   assign op_write = (state == S_IDLE) ? req_write  : wr_q;
   assign op_size  = (state == S_IDLE) ? in_size    : size_q;
   assign op_off   = (state == S_IDLE) ? in_off     : off_q;
   assign op_idx   = (state == S_IDLE) ? in_idx     : idx_q;
   assign op_wdat  = (state == S_IDLE) ? write_data : wdat_q;
   assign op_err   = (state == S_IDLE) ? in_err     : err_q;

   assign enter_resp = !reset && (state_nxt == S_RESP) && (state != S_RESP);
   assign mem_we     = enter_resp && op_write && !op_err;

   always_comb begin
      be    = 4'b1111;
      wlane = op_wdat;
      case (op_size)
         2'b00: begin
            be    = 4'b0001 << op_off;
            wlane = {4{op_wdat[7:0]}};
         end
         2'b01: begin
            be    = op_off[1] ? 4'b1100 : 4'b0011;
            wlane = {2{op_wdat[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = op_wdat;
         end
      endcase
   end

   // Memory contents deliberately survive reset
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[op_idx][8*b +: 8] <= wlane[8*b +: 8];
            end
         end
      end
      if (enter_resp) begin
         load_word <= mem[op_idx];
      end
   end

   assign sel_byte = load_word[{off_q, 3'b000} +: 8];
   assign sel_half = off_q[1] ? load_word[31:16] : load_word[15:0];

   always_comb begin
      fmt = load_word;
      case (size_q)
         2'b00:   fmt = {{24{!uns_q && sel_byte[7]}}, sel_byte};
         2'b01:   fmt = {{16{!uns_q && sel_half[15]}}, sel_half};
         default: fmt = load_word;
      endcase
   end

   assign read_data = (resp_valid && !wr_q && !err_q) ? fmt : 32'd0;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
   assign error = resp_valid && err_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_valid0;
   logic        req_ready, req_ready0;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        resp_valid, resp_valid0;
   logic [31:0] read_data, read_data0;
   logic        error, error0;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd;
   logic        er;
   int          lat;
   logic        seen;

   always #5 clock = ~clock;

   mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .address(address), .write_data(write_data),
      .resp_valid(resp_valid), .read_data(read_data), .error(error)
   );

   mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .address(address), .write_data(write_data),
      .resp_valid(resp_valid0), .read_data(read_data0), .error(error0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One request on instance z (0: two wait states, 1: none); returns data, error and latency in cycles
   task automatic do_req(input bit z, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rdo, output logic ero, output int lato);
      int guard;
      @(negedge clock);
      req_write = w; req_size = sz; req_unsigned = u; address = a; write_data = wd;
      if (z) req_valid0 = 1'b1; else req_valid = 1'b1;
      guard = 0;
      while (!(z ? req_ready0 : req_ready) && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0; req_valid0 = 1'b0;
      lato = 0; rdo = 32'hxxxxxxxx; ero = 1'bx;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (z ? resp_valid0 : resp_valid) begin
            lato = n;
            rdo  = z ? read_data0 : read_data;
            ero  = z ? error0 : error;
            break;
         end
      end
      @(negedge clock);
      chk("resp_one_cycle", {31'd0, (z ? resp_valid0 : resp_valid)}, 32'd0);
   endtask

   // req_valid held high across two loads; records negedge indices of acceptances and responses
   task automatic held_pair(input bit z, input int a2, input int r1, input int r2);
      int nacc, nresp;
      int acc [4];
      int rsp [4];
      nacc = 0; nresp = 0;
      for (int k = 0; k < 4; k++) begin acc[k] = -1; rsp[k] = -1; end
      @(negedge clock);
      req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; address = 32'h0; write_data = 32'h0;
      if (z) req_valid0 = 1'b1; else req_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if ((z ? req_valid0 : req_valid) && (z ? req_ready0 : req_ready) && nacc < 4) begin
            acc[nacc] = i; nacc++;
         end
         if ((z ? resp_valid0 : resp_valid) && nresp < 4) begin
            rsp[nresp] = i; nresp++;
         end
         if (nacc == 2 && (z ? req_valid0 : req_valid)) begin
            @(posedge clock);
            #1;
            req_valid = 1'b0; req_valid0 = 1'b0;
         end
         @(negedge clock);
      end
      chk("held_acc_count", nacc, 2);
      chk("held_second_accept", acc[1], a2);
      chk("held_resp_count", nresp, 2);
      chk("held_first_resp", rsp[0], r1);
      chk("held_second_resp", rsp[1], r2);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
      req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; address = 32'h0; write_data = 32'h0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_req_ready0", {31'd0, req_ready0}, 32'd0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

      // word store then load
      do_req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk("st_w10_lat", lat, 3);
      chk("st_w10_rdata", rd, 32'd0);
      chk("st_w10_err", {31'd0, er}, 32'd0);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
      chk("ld_w10_lat", lat, 3);
      chk("ld_w10", rd, 32'hDEADBEEF);

      // byte store into a known word
      do_req(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
      do_req(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, rd, er, lat);
      do_req(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, er, lat);
      chk("ld_b21_signed", rd, 32'hFFFFFF80);
      do_req(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat);
      chk("ld_b21_unsigned", rd, 32'h00000080);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
      chk("ld_w20_after_byte", rd, 32'h11228044);

      // halfword loads
      do_req(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat);
      chk("ld_h12_signed", rd, 32'hFFFFDEAD);
      do_req(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat);
      chk("ld_h10_unsigned", rd, 32'h0000BEEF);
      do_req(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat);
      chk("ld_h10_signed", rd, 32'hFFFFBEEF);

      // misaligned word load
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, er, lat);
      chk("ld_w13_lat", lat, 3);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      chk("ld_w13_rdata", rd, 32'd0);
      chk("ld_w13_err", {31'd0, er}, 32'd1);
`else
      chk("ld_w13_rdata", rd, 32'hDEADBEEF);
      chk("ld_w13_err", {31'd0, er}, 32'd0);
`endif

      // address wrap modulo 256 bytes
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h110, 32'h0, rd, er, lat);
      chk("ld_wrap_110", rd, 32'hDEADBEEF);

      // half store upper lanes, byte store ignoring upper data bits
      do_req(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000CAFE, rd, er, lat);
      do_req(0, 1'b1, 2'b00, 1'b0, 32'h23, 32'hFFFFFF55, rd, er, lat);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
      chk("ld_w20_after_half", rd, 32'h55FE8044);
      do_req(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lat);
      chk("ld_h22_unsigned", rd, 32'h000055FE);

      // misaligned half store, then size-11 load
      do_req(0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h00009999, rd, er, lat);
      chk("st_h21_lat", lat, 3);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      chk("st_h21_err", {31'd0, er}, 32'd1);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
      chk("ld_w20_after_mis", rd, 32'h55FE8044);
      do_req(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, er, lat);
      chk("ld_sz11_rdata", rd, 32'd0);
      chk("ld_sz11_err", {31'd0, er}, 32'd1);
`else
      chk("st_h21_err", {31'd0, er}, 32'd0);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
      chk("ld_w20_after_mis", rd, 32'h55FE9999);
      do_req(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, er, lat);
      chk("ld_sz11_rdata", rd, 32'h55FE9999);
      chk("ld_sz11_err", {31'd0, er}, 32'd0);
`endif

      // reset during WAIT abandons the store
      do_req(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hAAAA5555, rd, er, lat);
      @(negedge clock);
      req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; address = 32'h40; write_data = 32'h12345678;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rstw_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rstw_read_data", read_data, 32'd0);
      chk("rstw_error", {31'd0, error}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rstw_ready_release", {31'd0, req_ready}, 32'd1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clock);
         if (resp_valid) seen = 1'b1;
      end
      chk("rstw_no_resp", {31'd0, seen}, 32'd0);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
      chk("rstw_ld_w40", rd, 32'hAAAA5555);

      // back-to-back acceptance with req_valid held
      held_pair(0, 4, 3, 7);

      // zero wait states
      do_req(1, 1'b1, 2'b10, 1'b0, 32'h04, 32'hA5A5C3C3, rd, er, lat);
      chk("w0_st_lat", lat, 1);
      do_req(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, rd, er, lat);
      chk("w0_ld_lat", lat, 1);
      chk("w0_ld_wrap", rd, 32'hA5A5C3C3);
      do_req(1, 1'b0, 2'b00, 1'b0, 32'h04, 32'h0, rd, er, lat);
      chk("w0_ld_b04_signed", rd, 32'hFFFFFFC3);
      held_pair(1, 2, 1, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response (0..15).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 invalid.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port address  input  32  byte address.
REQ-011 SHALL have port write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse for loads and stores.
REQ-013 SHALL have port read_data  output  32  load result, valid only while resp_valid.
REQ-014 SHALL have port error  output  1  access fault, valid only while resp_valid.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE with reset low.
REQ-016 SHALL accept a request on the rising edge where req_valid && req_ready, latching req_write, req_size, req_unsigned, address and write_data.
REQ-017 On acceptance, SHALL load the wait counter with WAIT_CYCLES and enter WAIT; with WAIT_CYCLES = 0, SHALL enter RESP directly.
REQ-018 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where the counter is 0.
REQ-019 SHALL assert resp_valid for exactly one cycle, in the (WAIT_CYCLES+1)th cycle after the acceptance edge, then return to IDLE.
REQ-020 SHALL ignore req_valid while req_ready = 0; the next acceptance is no earlier than the cycle after resp_valid.
REQ-021 SHALL select the word by address[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-022 SHALL update memory on the edge entering RESP: byte writes lane address[1:0]; half writes lanes {address[1],0} and {address[1],1}; word writes all four lanes; other lanes are unchanged.
REQ-023 SHALL return loads from the lane(s) selected as in REQ-022, right-aligned, sign- or zero-extended per req_unsigned; word loads ignore req_unsigned.
REQ-024 SHALL drive read_data = 0 for stores and whenever resp_valid = 0.
REQ-025 SHALL treat as misaligned: half with address[0] = 1; word with address[1:0] != 0; any req_size = 11.

Reset
REQ-026 While reset is high, SHALL hold state IDLE, counter 0, resp_valid 0, read_data 0, error 0, and req_ready 0.
REQ-027 Reset asserted in WAIT or RESP SHALL abandon the request: no resp_valid, and no memory write if not yet performed.
REQ-028 SHALL NOT reset memory contents; req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 With macro MEM_RESPONDER_ALIGN_CHECK_EN defined, a misaligned request SHALL complete with error = 1, read_data = 0 and no memory write; the response timing SHALL be unchanged.
REQ-030 Without MEM_RESPONDER_ALIGN_CHECK_EN, error SHALL be tied to 0; misaligned halfword and word accesses SHALL clear the offending low address bits, and req_size = 11 SHALL be treated as a word access.

Verification
REQ-031 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> resp_valid in the 3rd cycle after each acceptance; read_data = 0xDEADBEEF.
REQ-032 Store byte 0x80 at 0x21 -> signed byte load at 0x21 = 0xFFFFFF80; unsigned = 0x00000080; word load at 0x20 has 0x80 in [15:8] and other lanes unchanged.
REQ-033 With 0xDEADBEEF at 0x10 -> signed half load at 0x12 = 0xFFFFDEAD; unsigned half load at 0x10 = 0x0000BEEF.
REQ-034 Word load at 0x13: with the macro -> error = 1, read_data = 0; without -> read_data = contents of word 0x10, error = 0.
REQ-035 Store word 0x12345678 to 0x40, with reset pulsed during WAIT -> no resp_valid; later load at 0x40 returns the prior value; req_ready = 1 in the cycle after reset release.
REQ-036 req_valid held high for two requests -> second acceptance in the cycle after the first resp_valid; no acceptance while req_ready = 0; with WAIT_CYCLES = 0, resp_valid in the cycle after acceptance.
